// File: rtl/sa_fifo_ctrl_32x64.sv
// Valid/ready FIFO controller driving a 32x64 registered-read RAM, with a 2-entry output skid
// buffer that hides the read latency. Define SA_FIFO_BYPASS_EN to let writes skip an empty RAM.
module sa_fifo_ctrl_32x64 #(
    parameter int unsigned DW = 64,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          wr_req,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_req,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    input  logic [DW-1:0] ram_dout,
    input  logic [31:0]   pwrbus_ram_pd
);

    localparam int unsigned Depth = 1 << AW;
    localparam logic [AW:0] CntFull = (AW + 1)'(Depth);

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   ram_cnt_q, ram_cnt_d;
    logic          inflight_q;
    logic          wr_ready_q;
    logic [1:0]    ob_cnt_q, ob_cnt_d, ob_after_pop;
    logic [DW-1:0] ob0_q, ob1_q, ob0_d, ob1_d;
    logic [2:0]    ob_pending;
    logic          accept, pop, bypass, push;
    logic [DW-1:0] push_data;

    // Power bus is routed to the RAM by the parent; nothing to do here.
    logic unused_pwrbus;
    assign unused_pwrbus = ^pwrbus_ram_pd;

    assign accept       = wr_req & wr_ready_q;
    assign pop          = (ob_cnt_q != 2'd0) & rd_ready;
    assign ob_after_pop = ob_cnt_q - {1'b0, pop};
    // Slots already claimed once this cycle's pop and last cycle's read are accounted for.
    assign ob_pending   = {1'b0, ob_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

`ifdef SA_FIFO_BYPASS_EN
    // Nothing older is in the RAM or in flight, so the buffer tail can take the write directly.
    assign bypass = accept & (ram_cnt_q == '0) & ~inflight_q & (ob_after_pop < 2'd2);
`else
    assign bypass = 1'b0;
`endif

    assign ram_we    = accept & ~bypass;
    assign ram_wa    = wr_ptr_q;
    assign ram_di    = wr_data;
    assign ram_re    = (ram_cnt_q != '0) & (ob_pending < 3'd2);
    assign ram_ra    = rd_ptr_q;
    assign wr_ready  = wr_ready_q;
    assign rd_req    = (ob_cnt_q != 2'd0);
    assign rd_data   = ob0_q;

    assign push      = inflight_q | bypass;
    assign push_data = inflight_q ? ram_dout : wr_data;

    always_comb begin
        ram_cnt_d = ram_cnt_q + {{AW{1'b0}}, ram_we} - {{AW{1'b0}}, ram_re};
        ob_cnt_d  = ob_after_pop + {1'b0, push};
    end

    always_comb begin
        ob0_d = ob0_q;
        ob1_d = ob1_q;
        // Shift only when a second entry exists so the head holds its value once empty.
        if (pop && ob_cnt_q == 2'd2) begin
            ob0_d = ob1_q;
        end
        if (push) begin
            if (ob_after_pop == 2'd0) begin
                ob0_d = push_data;
            end else begin
                ob1_d = push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            wr_ready_q <= 1'b0;
            ob_cnt_q   <= 2'd0;
            ob0_q      <= '0;
            ob1_q      <= '0;
        end else begin
            if (ram_we) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (ram_re) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= ram_re;
            wr_ready_q <= (ram_cnt_d != CntFull);
            ob_cnt_q   <= ob_cnt_d;
            ob0_q      <= ob0_d;
            ob1_q      <= ob1_d;
        end
    end

endmodule

// File: tb/tb_sa_fifo_ctrl_32x64.sv
// Directed bench for sa_fifo_ctrl_32x64 with a behavioural registered-read RAM.
module tb_sa_fifo_ctrl_32x64;

    logic        clk;
    logic        reset_;
    logic        wr_req;
    logic        wr_ready;
    logic [63:0] wr_data;
    logic        rd_req;
    logic        rd_ready;
    logic [63:0] rd_data;
    logic [4:0]  ram_wa;
    logic        ram_we;
    logic [63:0] ram_di;
    logic [4:0]  ram_ra;
    logic        ram_re;
    logic [63:0] ram_dout;
    logic [31:0] pwrbus_ram_pd;

    logic [63:0] mem [32];

    int n_checks;
    int n_errors;

`ifdef SA_FIFO_BYPASS_EN
    localparam int Latency = 1;
`else
    localparam int Latency = 3;
`endif

    sa_fifo_ctrl_32x64 dut (
        .clk           (clk),
        .reset_        (reset_),
        .wr_req        (wr_req),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .rd_req        (rd_req),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .ram_wa        (ram_wa),
        .ram_we        (ram_we),
        .ram_di        (ram_di),
        .ram_ra        (ram_ra),
        .ram_re        (ram_re),
        .ram_dout      (ram_dout),
        .pwrbus_ram_pd (pwrbus_ram_pd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ram_dout <= mem[ram_ra];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          accepts;
        int          early_block;
        int          nw;
        int          exp_i;
        int          first_pop;
        int          bubbles;
        int          stalls;
        int          wait_c;
        logic [63:0] exp_word;
        logic [63:0] sb [$];

        n_checks      = 0;
        n_errors      = 0;
        reset_        = 1'b0;
        wr_req        = 1'b0;
        wr_data       = '0;
        rd_ready      = 1'b0;
        pwrbus_ram_pd = '0;
        ram_dout      = '0;

        // Reset state
        #1;
        check("rst_wr_ready", 64'(wr_ready), 64'd0);
        check("rst_rd_req", 64'(rd_req), 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        check("rst_ram_we", 64'(ram_we), 64'd0);
        check("rst_ram_re", 64'(ram_re), 64'd0);
        step();
        step();
        reset_ = 1'b1;
        check("rel_wr_ready_0", 64'(wr_ready), 64'd0);
        step();
        check("rel_wr_ready_1", 64'(wr_ready), 64'd1);

        // Single write, latency
        rd_ready = 1'b1;
        wr_req   = 1'b1;
        wr_data  = 64'hDEAD_BEEF_0000_0001;
        check("single_accept", 64'(wr_ready), 64'd1);
        step();
        wr_req = 1'b0;
        for (int c = 1; c < Latency; c++) begin
            check("single_early", 64'(rd_req), 64'd0);
            step();
        end
        check("single_rd_req", 64'(rd_req), 64'd1);
        check("single_data", rd_data, 64'hDEAD_BEEF_0000_0001);
        step();
        check("single_gone", 64'(rd_req), 64'd0);
        check("single_hold", rd_data, 64'hDEAD_BEEF_0000_0001);

        // Fill to 34 with no reads
        rd_ready    = 1'b0;
        accepts     = 0;
        early_block = 0;
        for (int c = 0; c < 40 && accepts < 34; c++) begin
            wr_req  = 1'b1;
            wr_data = 64'd100 + 64'(accepts);
            if (wr_ready) accepts++;
            else early_block = 1;
            step();
        end
        check("fill_no_block", 64'(early_block), 64'd0);
        check("fill_accepts", 64'(accepts), 64'd34);
        wr_data = 64'd999;
        check("full_wr_ready", 64'(wr_ready), 64'd0);
        check("full_no_we", 64'(ram_we), 64'd0);
        step();
        wr_req = 1'b0;
        check("full_rd_req", 64'(rd_req), 64'd1);
        check("full_head", rd_data, 64'd100);

        // One pop from full frees a slot
        rd_ready = 1'b1;
        check("pop_still_full", 64'(wr_ready), 64'd0);
        step();
        rd_ready = 1'b0;
        check("refill_ready", 64'(wr_ready), 64'd1);
        check("refill_head", rd_data, 64'd101);
        wr_req  = 1'b1;
        wr_data = 64'd134;
        step();
        wr_req   = 1'b0;
        rd_ready = 1'b1;
        exp_word = 64'd101;
        for (int c = 0; c < 80 && exp_word != 64'd135; c++) begin
            if (rd_req) begin
                check("drain_data", rd_data, exp_word);
                exp_word++;
            end
            step();
        end
        check("drain_count", exp_word, 64'd135);
        check("drain_empty", 64'(rd_req), 64'd0);

        // Continuous 100-word stream
        nw        = 0;
        exp_i     = 0;
        first_pop = -1;
        bubbles   = 0;
        stalls    = 0;
        for (int c = 0; c < 200 && exp_i < 100; c++) begin
            wr_req  = (nw < 100);
            wr_data = 64'(nw);
            if (wr_req && wr_ready) nw++;
            else if (nw < 100) stalls++;
            if (rd_req) begin
                check("stream_data", rd_data, 64'(exp_i));
                if (first_pop < 0) first_pop = c;
                exp_i++;
            end else if (first_pop >= 0) begin
                bubbles++;
            end
            step();
        end
        wr_req = 1'b0;
        check("stream_count", 64'(exp_i), 64'd100);
        check("stream_latency", 64'(first_pop), 64'(Latency));
        check("stream_bubbles", 64'(bubbles), 64'd0);
        check("stream_stalls", 64'(stalls), 64'd0);

        // Random traffic against a scoreboard
        for (int c = 0; c < 5000; c++) begin
            wr_req   = 1'($urandom_range(1, 0));
            wr_data  = {$urandom, $urandom};
            rd_ready = 1'($urandom_range(1, 0));
            if (wr_req && wr_ready) sb.push_back(wr_data);
            if (rd_req && rd_ready) begin
                if (sb.size() == 0) check("rand_spurious", 64'd1, 64'd0);
                else check("rand_data", rd_data, sb.pop_front());
            end
            if (sb.size() > 34) check("rand_overfill", 64'(sb.size()), 64'd34);
            step();
        end
        wr_req   = 1'b0;
        rd_ready = 1'b1;
        for (int c = 0; c < 100 && sb.size() != 0; c++) begin
            if (rd_req) check("rand_drain", rd_data, sb.pop_front());
            step();
        end
        check("rand_left", 64'(sb.size()), 64'd0);
        check("rand_empty", 64'(rd_req), 64'd0);

        // Reset with a read in flight
        wr_req  = 1'b1;
        wr_data = 64'h0000_AAAA_0000_AAAA;
        step();
        wr_req = 1'b0;
        check("mid_issue", 64'(ram_re), 64'd1);
        step();
        reset_ = 1'b0;
        #1;
        check("mid_rd_req", 64'(rd_req), 64'd0);
        check("mid_wr_ready", 64'(wr_ready), 64'd0);
        check("mid_ram_re", 64'(ram_re), 64'd0);
        step();
        step();
        reset_ = 1'b1;
        step();
        check("post_ready", 64'(wr_ready), 64'd1);
        for (int c = 0; c < 4; c++) begin
            check("post_no_stale", 64'(rd_req), 64'd0);
            step();
        end
        wr_req  = 1'b1;
        wr_data = 64'h0000_CAFE_0000_CAFE;
        step();
        wr_req = 1'b0;
        wait_c = 0;
        while (!rd_req && wait_c < 10) begin
            step();
            wait_c++;
        end
        check("post_latency", 64'(wait_c + 1), 64'(Latency));
        check("post_data", rd_data, 64'h0000_CAFE_0000_CAFE);
        step();
        check("post_alone", 64'(rd_req), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
